test_monitor: RTL and testbench
===============================

# test_monitor

Memory-mapped self-check unit for core and SoC benches, and for on-board bring-up. Software writes operands and a command code to a per-channel mailbox. The block compares the operands, counts passes and failures, and tracks per-channel done/fail states. A cycle watchdog flags runs that never finish. It sits as a DBus slave beside RAM, one channel per hart or per test thread, and replaces bench-side hierarchical peeking with synthesizable hardware.

## Interface
Parameters:
- NUM_CH, 1, number of independent channels (1..16)
- ADDR_WIDTH, 6, word address width; must be ≥ clog2(NUM_CH*4)
- CNT_WIDTH, 16, width of each pass/fail counter
- TIMEOUT_WIDTH, 32, watchdog counter width
- MAX_CYCLES, 2048, watchdog limit in cycles

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request
- wr_en  in  1  write request
- addr  in  ADDR_WIDTH  word address
- wr_data  in  32  write data
- wr_strobe  in  4  byte write strobe
- rd_data  out  32  read data
- all_done  out  1  every channel in MON_DONE
- any_fail  out  1  some channel in MON_FAILED, or any fail counter nonzero
- timeout  out  1  watchdog expired
- finished  out  1  all_done | any channel MON_FAILED | timeout
- passed  out  1  all_done & ~any_fail & ~timeout
- cmd_err  out  1  sticky flag: unknown command or malformed CMD write

## Operation
- Register map, per channel c, at word addresses c*4+k:
  - k=0 OPA (R/W)
  - k=1 OPB (R/W)
  - k=2 CMD (write-only, reads 0)
  - k=3 STATUS (RO): {fail_cnt[15:0], pass_cnt[15:0]}. Counters narrower than 16 bits are zero-extended; wider ones show their low 16 bits.
- Addresses ≥ NUM_CH*4: writes are ignored and reads return 0.
- OPA and OPB honour wr_strobe per byte.
- A CMD write with wr_strobe != 4'hF is ignored and sets cmd_err.
- Per-channel FSM states: MON_RUN (reset), MON_DONE, MON_FAILED. Transitions in MON_RUN:
  - CMD 0: OPA==OPB increments pass_cnt, otherwise fail_cnt; stays in MON_RUN.
  - CMD 1: forced failure; fail_cnt +1; stays in MON_RUN.
  - CMD 32'h0D15EA5E: go to MON_DONE.
  - CMD 32'hDEADBEEF: fail_cnt +1; go to MON_FAILED.
  - Any other CMD value: sets cmd_err; no state change.
- MON_DONE and MON_FAILED are terminal until reset; CMD writes there are ignored, with no cmd_err.
- Counters saturate at all-ones and never wrap.
- The watchdog counts up from 0 every cycle while finished=0. It freezes once finished=1.
- When the count reaches MAX_CYCLES with some channel still in MON_RUN, timeout goes to 1 and stays set.
- Reset, including mid-run: all registers, counters and FSMs clear to 0 / MON_RUN immediately.

## Timing
- Reset values: rd_data=0, all_done=0, any_fail=0, timeout=0, finished=0, passed=0, cmd_err=0.
- Writes are registered. State, counter and flag outputs update on the clock edge that samples the write and are visible the following cycle.
- The CMD-0 compare uses the OPA/OPB values held before the CMD edge. A single port forbids an operand write in the same cycle.
- Reads have 1-cycle latency: rd_data is valid the cycle after rd_en and holds until the next read. STATUS reflects all writes completed before the read edge.
- If rd_en and wr_en are both high, the write takes effect and rd_data returns the pre-write value.
- Status outputs are registered and combinationally decoded from FSM/counter state; no pulse outputs.

## Configuration
- TEST_MONITOR_TIMEOUT_EN defined: watchdog counter built, timeout behaves as above.
- Not defined: no watchdog counter; timeout tied to 0; finished depends only on channel states.

## Structure
- In package saratoga:
  - typedef enum mon_state_t {MON_RUN, MON_DONE, MON_FAILED}
  - constants MON_DONE_CODE, MON_FAIL_CODE, MON_CMD_CHECK=0, MON_CMD_FAIL=1
  - register offsets MON_OPA/OPB/CMD/STATUS
- Sub-module test_monitor_channel: OPA/OPB, FSM and counters for one channel, instantiated NUM_CH times via generate.
- The top level holds address decode, the read mux, flag reduction and the watchdog.

## Test plan
- NUM_CH=1: OPA=5, OPB=5, CMD=0, then OPB=6, CMD=0 -> STATUS reads 32'h0001_0001; any_fail=1.
- Two checks pass, then CMD=0x0D15EA5E -> all_done=1, finished=1, passed=1; a later CMD=0 leaves STATUS unchanged.
- NUM_CH=2: ch0 done, ch1 CMD=0xDEADBEEF -> all_done=0, any_fail=1, finished=1; ch1 STATUS fail field=1.
- CMD=0x1234 and a CMD write with strobe 4'h3 -> cmd_err=1, counters and state unchanged.
- TEST_MONITOR_TIMEOUT_EN with MAX_CYCLES=64 and no commands -> timeout=1 at watchdog count 64, finished=1, passed=0. Assert rst_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// Shared types and constants for the test_monitor self-check unit.
// Holds the channel FSM state type, the command codes and the register offsets.
package saratoga;

    typedef enum logic [1:0] {
        MON_RUN    = 2'd0,
        MON_DONE   = 2'd1,
        MON_FAILED = 2'd2
    } mon_state_t;

    // Command codes written to a channel's CMD register
    localparam logic [31:0] MON_CMD_CHECK = 32'h0000_0000;
    localparam logic [31:0] MON_CMD_FAIL  = 32'h0000_0001;
    localparam logic [31:0] MON_DONE_CODE = 32'h0D15_EA5E;
    localparam logic [31:0] MON_FAIL_CODE = 32'hDEAD_BEEF;

    // Word offsets within a channel's four-word register window
    localparam logic [1:0] MON_OPA    = 2'd0;
    localparam logic [1:0] MON_OPB    = 2'd1;
    localparam logic [1:0] MON_CMD    = 2'd2;
    localparam logic [1:0] MON_STATUS = 2'd3;

endpackage

// File: rtl/test_monitor_channel.sv
// One test_monitor channel: operand registers, the run/done/failed FSM and the
// saturating pass/fail counters. The top decodes the address, so wr_en here is
// already qualified for this channel.
module test_monitor_channel
    import saratoga::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [1:0]           offset,
    input  logic [31:0]          wr_data,
    input  logic [3:0]           wr_strobe,
    output logic [31:0]          opa,
    output logic [31:0]          opb,
    output mon_state_t           state,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic                 cmd_err_set
);

    logic [31:0]          opa_reg;
    logic [31:0]          opb_reg;
    mon_state_t           state_reg;
    logic [CNT_WIDTH-1:0] pass_cnt_reg;
    logic [CNT_WIDTH-1:0] fail_cnt_reg;

    logic cmd_wr;
    logic cmd_valid;
    logic cmd_known;

    // Commands are only acted on while running; terminal states swallow them silently
    always_comb begin
        cmd_wr    = wr_en && (offset == MON_CMD) && (state_reg == MON_RUN);
        cmd_valid = cmd_wr && (wr_strobe == 4'hF);
        cmd_known = (wr_data == MON_CMD_CHECK) || (wr_data == MON_CMD_FAIL) ||
                    (wr_data == MON_DONE_CODE) || (wr_data == MON_FAIL_CODE);
        cmd_err_set = cmd_wr && ((wr_strobe != 4'hF) || !cmd_known);
    end

    // Operand registers with per-byte write enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_reg <= '0;
            opb_reg <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strobe[b] && offset == MON_OPA) opa_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                if (wr_strobe[b] && offset == MON_OPB) opb_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // FSM and saturating counters; the check compares operands held before this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= MON_RUN;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
        end else if (cmd_valid) begin
            case (wr_data)
                MON_CMD_CHECK: begin
                    if (opa_reg == opb_reg) begin
                        if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + CNT_WIDTH'(1);
                    end else begin
                        if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + CNT_WIDTH'(1);
                    end
                end
                MON_CMD_FAIL: begin
                    if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + CNT_WIDTH'(1);
                end
                MON_DONE_CODE: begin
                    state_reg <= MON_DONE;
                end
                MON_FAIL_CODE: begin
                    if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + CNT_WIDTH'(1);
                    state_reg <= MON_FAILED;
                end
                default: begin
                end
            endcase
        end
    end

    assign opa      = opa_reg;
    assign opb      = opb_reg;
    assign state    = state_reg;
    assign pass_cnt = pass_cnt_reg;
    assign fail_cnt = fail_cnt_reg;

endmodule

// File: rtl/test_monitor.sv
// test_monitor top: memory-mapped self-check unit with NUM_CH channels.
// Holds address decode, the registered read mux, flag reduction and the
// cycle watchdog. The watchdog is built only when TEST_MONITOR_TIMEOUT_EN is
// defined; otherwise timeout is tied low.
module test_monitor
    import saratoga::*;
#(
    parameter int NUM_CH        = 1,
    parameter int ADDR_WIDTH    = 6,
    parameter int CNT_WIDTH     = 16,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int MAX_CYCLES    = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strobe,
    output logic [31:0]           rd_data,
    output logic                  all_done,
    output logic                  any_fail,
    output logic                  timeout,
    output logic                  finished,
    output logic                  passed,
    output logic                  cmd_err
);

    logic [ADDR_WIDTH-3:0] ch_idx;
    logic [1:0]            offset;
    logic                  addr_valid;
    logic [NUM_CH-1:0]     ch_sel;
    logic [NUM_CH-1:0]     cmd_err_set;

    logic [31:0]          opa_arr    [NUM_CH];
    logic [31:0]          opb_arr    [NUM_CH];
    logic [31:0]          status_arr [NUM_CH];
    logic [CNT_WIDTH-1:0] pass_arr   [NUM_CH];
    logic [CNT_WIDTH-1:0] fail_arr   [NUM_CH];
    mon_state_t           state_arr  [NUM_CH];

    logic [31:0] rd_mux;
    logic [31:0] rd_data_reg;
    logic        cmd_err_reg;
    logic        all_done_c;
    logic        any_failed_c;
    logic        any_cnt_fail_c;
    logic        any_run_c;
    logic        timeout_c;
    logic        finished_c;

    assign ch_idx     = addr[ADDR_WIDTH-1:2];
    assign offset     = addr[1:0];
    assign addr_valid = (32'(addr) < 32'(NUM_CH * 4));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_sel[gi] = addr_valid && (ch_idx == (ADDR_WIDTH-2)'(gi));

            test_monitor_channel #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_channel (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_en       (wr_en && ch_sel[gi]),
                .offset      (offset),
                .wr_data     (wr_data),
                .wr_strobe   (wr_strobe),
                .opa         (opa_arr[gi]),
                .opb         (opb_arr[gi]),
                .state       (state_arr[gi]),
                .pass_cnt    (pass_arr[gi]),
                .fail_cnt    (fail_arr[gi]),
                .cmd_err_set (cmd_err_set[gi])
            );

            // STATUS shows 16 bits per counter: narrow counters zero-extended, wide ones truncated
            if (CNT_WIDTH >= 16) begin : g_wide
                assign status_arr[gi] = {fail_arr[gi][15:0], pass_arr[gi][15:0]};
            end else begin : g_narrow
                assign status_arr[gi] = {{(16-CNT_WIDTH){1'b0}}, fail_arr[gi],
                                         {(16-CNT_WIDTH){1'b0}}, pass_arr[gi]};
            end
        end
    endgenerate

    // Read mux over the selected channel; CMD and unmapped addresses read zero
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) begin
                case (offset)
                    MON_OPA:    rd_mux = opa_arr[c];
                    MON_OPB:    rd_mux = opb_arr[c];
                    MON_STATUS: rd_mux = status_arr[c];
                    default:    rd_mux = '0;
                endcase
            end
        end
    end

    // Reduce per-channel state into the summary flags
    always_comb begin
        all_done_c     = 1'b1;
        any_failed_c   = 1'b0;
        any_cnt_fail_c = 1'b0;
        any_run_c      = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_arr[c] != MON_DONE)   all_done_c     = 1'b0;
            if (state_arr[c] == MON_FAILED) any_failed_c   = 1'b1;
            if (state_arr[c] == MON_RUN)    any_run_c      = 1'b1;
            if (fail_arr[c] != '0)          any_cnt_fail_c = 1'b1;
        end
    end

    // Registered read data; a simultaneous write is not visible until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_mux;
        end
    end

    // Sticky command error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_reg <= 1'b0;
        end else if (|cmd_err_set) begin
            cmd_err_reg <= 1'b1;
        end
    end

`ifdef TEST_MONITOR_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wd_cnt_reg;
    logic                     timeout_reg;

    // Watchdog counts while unfinished; timeout rises on the edge the count reaches MAX_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else if (!finished_c) begin
            wd_cnt_reg <= wd_cnt_reg + TIMEOUT_WIDTH'(1);
            if (any_run_c && (wd_cnt_reg == TIMEOUT_WIDTH'(MAX_CYCLES - 1))) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout_c = timeout_reg;
`else
    assign timeout_c = 1'b0;
`endif

    assign finished_c = all_done_c | any_failed_c | timeout_c;

    assign rd_data  = rd_data_reg;
    assign all_done = all_done_c;
    assign any_fail = any_failed_c | any_cnt_fail_c;
    assign timeout  = timeout_c;
    assign finished = finished_c;
    assign passed   = all_done_c & ~(any_failed_c | any_cnt_fail_c) & ~timeout_c;
    assign cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_test_monitor.sv
// Directed testbench for test_monitor (two channels, 4-bit counters, 64-cycle watchdog).
module tb_test_monitor;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic        wr_en;
    logic [5:0]  addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic [31:0] rd_data;
    logic        all_done;
    logic        any_fail;
    logic        timeout;
    logic        finished;
    logic        passed;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;

    test_monitor #(
        .NUM_CH        (2),
        .ADDR_WIDTH    (6),
        .CNT_WIDTH     (4),
        .TIMEOUT_WIDTH (32),
        .MAX_CYCLES    (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .rd_data   (rd_data),
        .all_done  (all_done),
        .any_fail  (any_fail),
        .timeout   (timeout),
        .finished  (finished),
        .passed    (passed),
        .cmd_err   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        addr = '0; wr_data = '0; wr_strobe = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wr_data = d; wr_strobe = s;
        @(negedge clk);
        wr_en = 1'b0; wr_strobe = '0;
        $display("wr addr=%0d data=%h strb=%h", a, d, s);
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
        $display("rd addr=%0d data=%h", a, d);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        @(negedge clk);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done got=%b exp=0", all_done); end
        checks++; if (any_fail !== 1'b0) begin errors++; $display("FAIL reset_any_fail got=%b exp=0", any_fail); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got=%b exp=0", finished); end
        checks++; if (passed !== 1'b0) begin errors++; $display("FAIL reset_passed got=%b exp=0", passed); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        bus_read(6'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", d); end
    endtask

    task automatic test_check();
        logic [31:0] d;
        do_reset();
        bus_write(6'd0, 32'd5, 4'hF);
        bus_write(6'd1, 32'd5, 4'hF);
        bus_write(6'd2, 32'd0, 4'hF);
        bus_write(6'd1, 32'd6, 4'hF);
        bus_write(6'd2, 32'd0, 4'hF);
        bus_read(6'd3, d);
        checks++; if (d !== 32'h0001_0001) begin errors++; $display("FAIL check_status got=%h exp=00010001", d); end
        checks++; if (any_fail !== 1'b1) begin errors++; $display("FAIL check_any_fail got=%b exp=1", any_fail); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL check_finished got=%b exp=0", finished); end
        bus_read(6'd1, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL check_opb got=%h exp=6", d); end
        bus_read(6'd2, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL check_cmd_read got=%h exp=0", d); end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        bus_write(6'd4, 32'hFFFF_FFFF, 4'hF);
        bus_write(6'd4, 32'h1234_5678, 4'h5);
        bus_read(6'd4, d);
        checks++; if (d !== 32'hFF34_FF78) begin errors++; $display("FAIL strobe_opa got=%h exp=ff34ff78", d); end
    endtask

    task automatic test_done();
        logic [31:0] d;
        do_reset();
        bus_write(6'd2, 32'd0, 4'hF);
        bus_write(6'd2, 32'd0, 4'hF);
        bus_write(6'd2, 32'h0D15_EA5E, 4'hF);
        checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL done_partial got=%b exp=0", all_done); end
        bus_write(6'd6, 32'h0D15_EA5E, 4'hF);
        checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_all_done got=%b exp=1", all_done); end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL done_finished got=%b exp=1", finished); end
        checks++; if (passed !== 1'b1) begin errors++; $display("FAIL done_passed got=%b exp=1", passed); end
        bus_write(6'd0, 32'd1, 4'hF);
        bus_write(6'd2, 32'd0, 4'hF);
        bus_read(6'd3, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL done_frozen got=%h exp=00000002", d); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL done_cmd_err got=%b exp=0", cmd_err); end
    endtask

    task automatic test_fail();
        logic [31:0] d;
        do_reset();
        bus_write(6'd2, 32'h0D15_EA5E, 4'hF);
        bus_write(6'd6, 32'hDEAD_BEEF, 4'hF);
        checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL fail_all_done got=%b exp=0", all_done); end
        checks++; if (any_fail !== 1'b1) begin errors++; $display("FAIL fail_any_fail got=%b exp=1", any_fail); end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL fail_finished got=%b exp=1", finished); end
        checks++; if (passed !== 1'b0) begin errors++; $display("FAIL fail_passed got=%b exp=0", passed); end
        bus_read(6'd7, d);
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL fail_status got=%h exp=00010000", d); end
    endtask

    task automatic test_cmd_err();
        logic [31:0] d;
        do_reset();
        bus_write(6'd2, 32'h0000_1234, 4'hF);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL cmderr_unknown got=%b exp=1", cmd_err); end
        bus_read(6'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cmderr_unknown_status got=%h exp=0", d); end
        do_reset();
        bus_write(6'd2, 32'h0D15_EA5E, 4'h3);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL cmderr_strobe got=%b exp=1", cmd_err); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL cmderr_strobe_state got=%b exp=0", finished); end
        bus_write(6'd2, 32'd1, 4'hF);
        bus_read(6'd3, d);
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL cmd_forced_fail got=%h exp=00010000", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        bus_write(6'd0, 32'hA5A5_0001, 4'hF);
        bus_write(6'd8, 32'h1111_2222, 4'hF);
        bus_write(6'd40, 32'hDEAD_BEEF, 4'hF);
        bus_read(6'd8, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_read got=%h exp=0", d); end
        bus_read(6'd0, d);
        checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL oor_opa_intact got=%h exp=a5a50001", d); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL oor_no_state got=%b exp=0", finished); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; addr = 6'd0; wr_data = 32'hCAFE_F00D; wr_strobe = 4'hF;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; wr_strobe = '0;
        $display("rdwr addr=0 data=cafef00d read=%h", rd_data);
        checks++; if (rd_data !== 32'hA5A5_0001) begin errors++; $display("FAIL rdwr_old got=%h exp=a5a50001", rd_data); end
        bus_read(6'd0, d);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL rdwr_new got=%h exp=cafef00d", d); end
    endtask

    task automatic test_saturate();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 17; i++) bus_write(6'd2, 32'd1, 4'hF);
        bus_read(6'd3, d);
        checks++; if (d !== 32'h000F_0000) begin errors++; $display("FAIL sat_status got=%h exp=000f0000", d); end
        // Asynchronous reset away from any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (any_fail !== 1'b0) begin errors++; $display("FAIL async_any_fail got=%b exp=0", any_fail); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL async_rd_data got=%h exp=0", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_watchdog();
        do_reset();
`ifdef TEST_MONITOR_TIMEOUT_EN
        repeat (63) @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_early got=%b exp=0", timeout); end
        @(negedge clk);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout got=%b exp=1", timeout); end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL wd_finished got=%b exp=1", finished); end
        checks++; if (passed !== 1'b0) begin errors++; $display("FAIL wd_passed got=%b exp=0", passed); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_async_timeout got=%b exp=0", timeout); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL wd_async_finished got=%b exp=0", finished); end
        @(negedge clk);
        rst_n = 1'b1;
`else
        repeat (100) @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_off_timeout got=%b exp=0", timeout); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL wd_off_finished got=%b exp=0", finished); end
`endif
        $display("watchdog scenario done");
    endtask

    initial begin
        test_reset();
        test_check();
        test_strobe();
        test_done();
        test_fail();
        test_cmd_err();
        test_out_of_range();
        test_back_to_back();
        test_saturate();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
